// File: rtl/gp_regfile_pkg.sv
// Shared constants and types for the general-purpose register file.
// Optional feature macro: GP_REGFILE_BYPASS_EN (write-to-read forwarding).
package gp_regfile_pkg;

   localparam int          DEFAULT_DATA_W   = 16;
   localparam int          DEFAULT_NUM_REGS = 8;
   localparam int          DEFAULT_ADDR_W   = 3;
   localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;
   localparam int          DEFAULT_PC_STEP  = 1;

   // Register index and data word at the default geometry.
   typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;
   typedef logic [DEFAULT_DATA_W-1:0] data_word_t;

endpackage : gp_regfile_pkg

// File: rtl/gp_pc_counter.sv
// Program counter: load has priority over increment, increment wraps
// modulo 2**DATA_W, otherwise the value holds.
module gp_pc_counter
   import gp_regfile_pkg::*;
#(
   parameter int                DATA_W   = DEFAULT_DATA_W,
   parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(DEFAULT_RESET_PC),
   parameter int                PC_STEP  = DEFAULT_PC_STEP
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              pc_load,
   input  logic              pc_inc,
   input  logic [DATA_W-1:0] pc_in,
   output logic [DATA_W-1:0] pc_out
);

   localparam logic [DATA_W-1:0] STEP = DATA_W'(PC_STEP);

   logic [DATA_W-1:0] pc_q;
   logic [DATA_W-1:0] pc_d;

   // Next PC: load beats increment; the add simply truncates to wrap.
   always_comb begin
      pc_d = pc_q;
      if (pc_load) begin
         pc_d = pc_in;
      end else if (pc_inc) begin
         pc_d = pc_q + STEP;
      end
   end

   // PC state register, cleared to the reset vector asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_out = pc_q;

endmodule : gp_pc_counter

// File: rtl/gp_register_file.sv
// General-purpose register file: NUM_REGS x DATA_W array with two
// combinational read ports, one synchronous write port, a pending
// scoreboard for outstanding results and an integrated program counter.
// Optional feature macro: GP_REGFILE_BYPASS_EN forwards the write data to
// a read port addressing the register being written in the same cycle.
// Legal configurations need NUM_REGS >= 2 and 2**ADDR_W >= NUM_REGS.
module gp_register_file
   import gp_regfile_pkg::*;
#(
   parameter int                DATA_W   = DEFAULT_DATA_W,
   parameter int                NUM_REGS = DEFAULT_NUM_REGS,
   parameter int                ADDR_W   = DEFAULT_ADDR_W,
   parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(DEFAULT_RESET_PC),
   parameter int                PC_STEP  = DEFAULT_PC_STEP
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [ADDR_W-1:0]   rd_a_addr,
   output logic [DATA_W-1:0]   rd_a_data,
   output logic                rd_a_busy,
   input  logic [ADDR_W-1:0]   rd_b_addr,
   output logic [DATA_W-1:0]   rd_b_data,
   output logic                rd_b_busy,
   input  logic                issue_en,
   input  logic [ADDR_W-1:0]   issue_addr,
   input  logic                pc_load,
   input  logic                pc_inc,
   input  logic [DATA_W-1:0]   pc_in,
   output logic [DATA_W-1:0]   pc_out,
   output logic [NUM_REGS-1:0] pending_vec,
   output logic                wr_err
);

   // One extra bit so the bound compare also works when NUM_REGS == 2**ADDR_W.
   localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(NUM_REGS);

   logic wr_in_range;
   logic wr_valid;
   logic issue_valid;

   assign wr_in_range = ({1'b0, wr_addr} < REG_LIMIT);
   assign wr_valid    = wr_en && wr_in_range;
   assign issue_valid = issue_en && ({1'b0, issue_addr} < REG_LIMIT);

   logic [NUM_REGS-1:0][DATA_W-1:0] reg_words;
   logic [NUM_REGS-1:0]             pend_q;
   logic [NUM_REGS-1:0]             pend_d;
   logic                            wr_err_q;
   logic                            wr_err_d;

   genvar gi;

   // ---------------- register array ----------------
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         logic [DATA_W-1:0] word_q;
         logic [DATA_W-1:0] word_d;

         assign word_d = (wr_valid && (wr_addr == ADDR_W'(gi))) ? wr_data : word_q;

         // Storage for one register; only a valid write to this index changes it.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               word_q <= '0;
            end else begin
               word_q <= word_d;
            end
         end

         assign reg_words[gi] = word_q;
      end
   endgenerate

   // ---------------- pending scoreboard ----------------
   // Write clears first, issue sets after, so a same-cycle issue to the
   // written register leaves the bit set for the new producer.
   always_comb begin
      pend_d = pend_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (wr_valid && (wr_addr == ADDR_W'(i))) begin
            pend_d[i] = 1'b0;
         end
         if (issue_valid && (issue_addr == ADDR_W'(i))) begin
            pend_d[i] = 1'b1;
         end
      end
   end

   // Scoreboard state; outstanding bits are dropped on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   // ---------------- out-of-range write flag ----------------
   assign wr_err_d = wr_en && !wr_in_range;

   // One-cycle error pulse following a write to a nonexistent register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_err_q <= 1'b0;
      end else begin
         wr_err_q <= wr_err_d;
      end
   end

   // ---------------- read ports ----------------
   logic [1:0][DATA_W-1:0] rd_data;
   logic [1:0]             rd_busy;

   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         logic [ADDR_W-1:0] addr;
         logic [DATA_W-1:0] data_c;
         logic              busy_c;

         assign addr = (gi == 0) ? rd_a_addr : rd_b_addr;

         // Read mux; unmatched (out-of-range) addresses fall through to zero.
         always_comb begin
            data_c = '0;
            busy_c = 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
               if (addr == ADDR_W'(i)) begin
                  data_c = reg_words[i];
                  busy_c = pend_q[i];
               end
            end
`ifdef GP_REGFILE_BYPASS_EN
            if (wr_valid && (wr_addr == addr)) begin
               data_c = wr_data;
               if (!(issue_en && (issue_addr == addr))) begin
                  busy_c = 1'b0;
               end
            end
`endif
         end

         assign rd_data[gi] = data_c;
         assign rd_busy[gi] = busy_c;
      end
   endgenerate

   assign rd_a_data = rd_data[0];
   assign rd_a_busy = rd_busy[0];
   assign rd_b_data = rd_data[1];
   assign rd_b_busy = rd_busy[1];

   assign pending_vec = pend_q;
   assign wr_err      = wr_err_q;

   // ---------------- program counter ----------------
   gp_pc_counter #(
      .DATA_W   (DATA_W),
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) u_pc (
      .clk     (clk),
      .reset   (reset),
      .pc_load (pc_load),
      .pc_inc  (pc_inc),
      .pc_in   (pc_in),
      .pc_out  (pc_out)
   );

endmodule : gp_register_file

// File: tb/tb_gp_register_file.sv
// Scoreboard bench for gp_register_file (NUM_REGS = 6, RESET_PC = 0x0100).
// Stimulus is applied 1 ns after each rising edge and pushes expected
// values into a queue; a monitor drains the queue on the falling edge.
module tb_gp_register_file;

   localparam int DATA_W   = 16;
   localparam int NUM_REGS = 6;
   localparam int ADDR_W   = 3;
`ifdef GP_REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                clk;
   logic                reset;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic [ADDR_W-1:0]   rd_a_addr;
   logic [DATA_W-1:0]   rd_a_data;
   logic                rd_a_busy;
   logic [ADDR_W-1:0]   rd_b_addr;
   logic [DATA_W-1:0]   rd_b_data;
   logic                rd_b_busy;
   logic                issue_en;
   logic [ADDR_W-1:0]   issue_addr;
   logic                pc_load;
   logic                pc_inc;
   logic [DATA_W-1:0]   pc_in;
   logic [DATA_W-1:0]   pc_out;
   logic [NUM_REGS-1:0] pending_vec;
   logic                wr_err;

   gp_register_file #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .RESET_PC (16'h0100),
      .PC_STEP  (1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_a_addr   (rd_a_addr),
      .rd_a_data   (rd_a_data),
      .rd_a_busy   (rd_a_busy),
      .rd_b_addr   (rd_b_addr),
      .rd_b_data   (rd_b_data),
      .rd_b_busy   (rd_b_busy),
      .issue_en    (issue_en),
      .issue_addr  (issue_addr),
      .pc_load     (pc_load),
      .pc_inc      (pc_inc),
      .pc_in       (pc_in),
      .pc_out      (pc_out),
      .pending_vec (pending_vec),
      .wr_err      (wr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum int {K_RDA, K_RDB, K_BUSYA, K_BUSYB, K_PC, K_PEND, K_WERR} kind_t;
   typedef struct {
      kind_t       kind;
      string       name;
      logic [15:0] value;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   done   = 1'b0;

   task automatic expect_val(input kind_t k, input string nm, input logic [15:0] v);
      exp_t e;
      e.kind  = k;
      e.name  = nm;
      e.value = v;
      exp_q.push_back(e);
   endtask

   function automatic logic [15:0] actual(input kind_t k);
      case (k)
         K_RDA:   return rd_a_data;
         K_RDB:   return rd_b_data;
         K_BUSYA: return {15'd0, rd_a_busy};
         K_BUSYB: return {15'd0, rd_b_busy};
         K_PC:    return pc_out;
         K_PEND:  return {10'd0, pending_vec};
         default: return {15'd0, wr_err};
      endcase
   endfunction

   task automatic check_now(input kind_t k, input string nm, input logic [15:0] v);
      logic [15:0] act;
      act = actual(k);
      checks++;
      if (act !== v) begin
         errors++;
         $display("FAIL %s actual=%h required=%h @%0t", nm, act, v, $time);
      end else begin
         $display("check %s value=%h @%0t", nm, act, $time);
      end
   endtask

   // Monitor: compare every queued expectation against the live outputs.
   always @(negedge clk) begin
      exp_t        e;
      logic [15:0] act;
      while (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         act = actual(e.kind);
         checks++;
         if (act !== e.value) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", e.name, act, e.value, $time);
         end else begin
            $display("check %s value=%h @%0t", e.name, act, $time);
         end
      end
   end

   // Watchdog: the run must complete within the time budget.
   initial begin
      #100000;
      if (!done) begin
         errors++;
         $display("FAIL watchdog expired @%0t", $time);
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      wr_en    = 1'b0;
      issue_en = 1'b0;
      pc_load  = 1'b0;
      pc_inc   = 1'b0;
   endtask

   initial begin
      reset      = 1'b0;
      wr_en      = 1'b0;
      wr_addr    = '0;
      wr_data    = '0;
      rd_a_addr  = 3'd3;
      rd_b_addr  = 3'd0;
      issue_en   = 1'b0;
      issue_addr = '0;
      pc_load    = 1'b0;
      pc_inc     = 1'b0;
      pc_in      = '0;
      repeat (2) @(posedge clk);

      // Reset held, then released
      step();
      #1;
      check_now(K_PC,   "rst_pc_now",   16'h0100);
      check_now(K_PEND, "rst_pend_now", 16'h0000);
      check_now(K_WERR, "rst_werr_now", 16'h0000);
      check_now(K_RDA,  "rst_rda_now",  16'h0000);
      expect_val(K_PC,   "rst_pc",   16'h0100);
      expect_val(K_PEND, "rst_pend", 16'h0000);
      expect_val(K_WERR, "rst_werr", 16'h0000);
      expect_val(K_RDA,  "rst_rda",  16'h0000);
      step();
      reset = 1'b1;
      expect_val(K_PC,   "rel_pc",   16'h0100);
      expect_val(K_PEND, "rel_pend", 16'h0000);
      for (int p = 0; p < 3; p++) begin
         step();
         rd_a_addr = ADDR_W'(2 * p);
         rd_b_addr = ADDR_W'(2 * p + 1);
         expect_val(K_RDA,   "rst_reg_a",  16'h0000);
         expect_val(K_RDB,   "rst_reg_b",  16'h0000);
         expect_val(K_BUSYA, "rst_busy_a", 16'h0000);
      end

      // Write r3, read on both ports in the same and the next cycle
      step();
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
      rd_a_addr = 3'd3; rd_b_addr = 3'd3;
      expect_val(K_RDA, "wr_same_a", BYP ? 16'hBEEF : 16'h0000);
      expect_val(K_RDB, "wr_same_b", BYP ? 16'hBEEF : 16'h0000);
      step();
      expect_val(K_RDA,  "wr_next_a", 16'hBEEF);
      expect_val(K_RDB,  "wr_next_b", 16'hBEEF);
      expect_val(K_WERR, "wr_ok_err", 16'h0000);

      // Scoreboard race on r5
      step();
      issue_en = 1'b1; issue_addr = 3'd5; rd_a_addr = 3'd5;
      expect_val(K_BUSYA, "iss_same_busy", 16'h0000);
      expect_val(K_PEND,  "iss_same_pend", 16'h0000);
      step();
      expect_val(K_BUSYA, "iss_busy", 16'h0001);
      expect_val(K_PEND,  "iss_pend", 16'h0020);
      step();
      expect_val(K_BUSYA, "iss_hold_busy", 16'h0001);
      step();
      wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234;
      issue_en = 1'b1; issue_addr = 3'd5;
      expect_val(K_BUSYA, "race_busy", 16'h0001);
      expect_val(K_RDA,   "race_rda",  BYP ? 16'h1234 : 16'h0000);
      step();
      wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h5678;
      expect_val(K_PEND,  "race_pend",  16'h0020);
      expect_val(K_BUSYA, "clr_busy_c", BYP ? 16'h0000 : 16'h0001);
      expect_val(K_RDA,   "clr_rda_c",  BYP ? 16'h5678 : 16'h1234);
      step();
      expect_val(K_PEND,  "clr_pend", 16'h0000);
      expect_val(K_BUSYA, "clr_busy", 16'h0000);
      expect_val(K_RDA,   "clr_rda",  16'h5678);

      // Issue and write to different registers in one cycle
      step();
      issue_en = 1'b1; issue_addr = 3'd1;
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h00A2;
      rd_b_addr = 3'd1;
      expect_val(K_BUSYB, "diff_busy_c", 16'h0000);
      step();
      issue_en = 1'b1; issue_addr = 3'd3;
      rd_a_addr = 3'd2;
      expect_val(K_PEND,  "diff_pend", 16'h0002);
      expect_val(K_RDA,   "diff_rda",  16'h00A2);
      expect_val(K_BUSYB, "diff_busy", 16'h0001);
      step();
      rd_b_addr = 3'd3;
      expect_val(K_PEND,  "pend_0a",    16'h000A);
      expect_val(K_BUSYB, "busy_r3",    16'h0001);

      // PC priority, wrap and hold
      step();
      pc_load = 1'b1; pc_inc = 1'b1; pc_in = 16'hFFFF;
      expect_val(K_PC, "pc_before", 16'h0100);
      step();
      pc_inc = 1'b1;
      expect_val(K_PC, "pc_load_prio", 16'hFFFF);
      step();
      expect_val(K_PC, "pc_wrap", 16'h0000);
      step();
      expect_val(K_PC, "pc_hold", 16'h0000);
      step();
      pc_load = 1'b1; pc_in = 16'h0041;
      step();
      pc_inc = 1'b1;
      expect_val(K_PC, "pc_load41", 16'h0041);
      step();
      expect_val(K_PC, "pc_inc42", 16'h0042);

      // Out-of-range write and issue to address 7
      step();
      wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hDEAD;
      issue_en = 1'b1; issue_addr = 3'd7;
      rd_a_addr = 3'd7; rd_b_addr = 3'd3;
      expect_val(K_RDA,   "oor_rda_c",  16'h0000);
      expect_val(K_BUSYA, "oor_busy_c", 16'h0000);
      expect_val(K_WERR,  "oor_err_c",  16'h0000);
      step();
      expect_val(K_WERR,  "oor_err",  16'h0001);
      expect_val(K_PEND,  "oor_pend", 16'h000A);
      expect_val(K_RDA,   "oor_rda",  16'h0000);
      expect_val(K_BUSYA, "oor_busy", 16'h0000);
      expect_val(K_RDB,   "oor_r3",   16'hBEEF);
      step();
      rd_b_addr = 3'd6;
      expect_val(K_WERR,  "oor_err_end", 16'h0000);
      expect_val(K_RDB,   "oor_r6",      16'h0000);
      expect_val(K_BUSYB, "oor_r6_busy", 16'h0000);
      expect_val(K_PC,    "pre_rst_pc",  16'h0042);
      expect_val(K_PEND,  "pre_rst_pend",16'h000A);

      // Asynchronous reset between edges with activity on the inputs
      step();
      reset = 1'b0;
      pc_inc = 1'b1; issue_en = 1'b1; issue_addr = 3'd0;
      rd_b_addr = 3'd3;
      #1;
      check_now(K_PC,   "arst_pc_now",   16'h0100);
      check_now(K_PEND, "arst_pend_now", 16'h0000);
      check_now(K_RDB,  "arst_r3_now",   16'h0000);
      expect_val(K_PC,   "arst_pc",   16'h0100);
      expect_val(K_PEND, "arst_pend", 16'h0000);
      expect_val(K_WERR, "arst_werr", 16'h0000);
      expect_val(K_RDB,  "arst_r3",   16'h0000);
      step();
      reset = 1'b1;
      expect_val(K_PC,   "arst_rel_pc",   16'h0100);
      expect_val(K_PEND, "arst_rel_pend", 16'h0000);
      step();
      rd_a_addr = 3'd5;
      expect_val(K_PC,  "arst_hold_pc", 16'h0100);
      expect_val(K_RDA, "arst_r5",      16'h0000);

      @(posedge clk);
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending expectations %0d @%0t", exp_q.size(), $time);
      end
      done = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_gp_register_file

// File: doc/gp_register_file.md
Name: gp_register_file

Overview:
- Parametrised successor to the fixed five-register CPU register set.
- Provides a general-purpose register array of NUM_REGS x DATA_W with:
  - two combinational read ports
  - one synchronous write port
  - an integrated program counter with load/increment
  - a per-register pending scoreboard for multi-cycle datapath ops
- Sits between the control unit (issue/PC control) and the ALU/memory writeback path.

Parameters:
- DATA_W, 16: register, PC and data width in bits.
- NUM_REGS, 8: number of general-purpose registers; must be ≥ 2.
- ADDR_W, 3: register address width; must satisfy 2**ADDR_W ≥ NUM_REGS.
- RESET_PC, 0: PC value loaded on reset.
- PC_STEP, 1: amount added to PC on increment.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- wr_en  input  1  write strobe
- wr_addr  input  ADDR_W  write register index
- wr_data  input  DATA_W  write data
- rd_a_addr  input  ADDR_W  read port A index
- rd_a_data  output  DATA_W  read port A data
- rd_a_busy  output  1  pending bit of rd_a_addr
- rd_b_addr  input  ADDR_W  read port B index
- rd_b_data  output  DATA_W  read port B data
- rd_b_busy  output  1  pending bit of rd_b_addr
- issue_en  input  1  mark issue_addr as pending
- issue_addr  input  ADDR_W  register whose result is outstanding
- pc_load  input  1  load PC from pc_in
- pc_inc  input  1  advance PC by PC_STEP
- pc_in  input  DATA_W  PC load value
- pc_out  output  DATA_W  current PC
- pending_vec  output  NUM_REGS  full scoreboard state
- wr_err  output  1  registered one-cycle pulse on an out-of-range write

Behaviour:
- Reset (reset = 0, asynchronous):
  - all registers = 0
  - pc_out = RESET_PC
  - pending_vec = 0
  - wr_err = 0
  - Reset takes effect immediately mid-operation. Outstanding pending bits are discarded.
- Write:
  - If wr_en and wr_addr < NUM_REGS, reg[wr_addr] ← wr_data at the clk edge.
  - If wr_addr ≥ NUM_REGS, the array is unchanged and wr_err = 1 on the next cycle only.
- Read:
  - rd_x_data = reg[rd_x_addr], combinational, zero-latency.
  - Out-of-range address returns 0 and busy = 0.
  - Both ports may read the same address.
  - Without bypass, a read of the register being written this cycle returns the old value; the new value is visible the cycle after the edge.
- PC:
  - pc_load has priority over pc_inc.
  - pc_inc computes pc + PC_STEP modulo 2**DATA_W; all-ones + 1 wraps to 0.
  - With neither asserted, the PC holds.
  - The PC is not addressable through the array.
- Scoreboard:
  - issue_en sets pending[issue_addr].
  - A valid write clears pending[wr_addr].
  - Same-cycle issue and write to the same address: the set wins, so the bit stays 1 (a new producer is outstanding).
  - Different addresses: both take effect.
  - issue_en with an out-of-range address is ignored.
  - rd_x_busy = pending[rd_x_addr], registered state, combinational select.
  - Writes to a non-pending register are legal and leave its bit at 0.
- No internal stall: the consumer is responsible for honouring busy.

Optional Feature:
- Macro: GP_REGFILE_BYPASS_EN.
- Defined:
  - Each read port forwards wr_data combinationally when wr_en && wr_addr == rd_x_addr && wr_addr < NUM_REGS.
  - rd_x_busy is also masked to 0 in that case unless issue_en targets the same address in that cycle.
- Undefined: reads return array contents only; busy reflects registered pending only.

Decomposition:
- Shared package gp_regfile_pkg:
  - default DATA_W / NUM_REGS / ADDR_W constants
  - RESET_PC default
  - a typedef for the register index and for the data word
- Natural sub-module: gp_pc_counter. It holds the PC register with load/increment/wrap and reuses the existing PC role as a parametrised block.
- The array, scoreboard and read muxes stay in the top module.

Test Plan:
- Reset check: hold reset = 0 with RESET_PC = 16'h0100, then release → pc_out = 0x0100, pending_vec = 0, all reads return 0, wr_err = 0.
- Write/read: write 0xBEEF to r3, then next cycle read A = r3 and B = r3 → both return 0xBEEF. Same-cycle read of r3 during the write returns the old value without the macro and 0xBEEF with it.
- Scoreboard race: issue r5 at cycle 1 → rd_a_busy = 1. At cycle 4, write r5 together with issue r5 → pending[5] stays 1. At cycle 5, write r5 alone → pending[5] = 0.
- PC priority/wrap: pc_load = 1 and pc_inc = 1 with pc_in = 0xFFFF → pc = 0xFFFF. Then pc_inc → 0x0000. Then idle → holds 0x0000.
- Out-of-range (NUM_REGS = 6): write to address 7 → wr_err pulses for exactly 1 cycle, the array is unchanged, and a read of address 7 returns 0 with busy 0.
- Async reset mid-op: assert reset between edges while pending_vec = 0x0A and PC = 0x0042 → outputs clear immediately, with no clk edge required.
